// File: rtl/eaglesong_msg_loader.sv
// Byte-stream front end for the Eaglesong absorb stage: packs 1..MAX_BYTES bytes little-endian.
// Define EAGLESONG_LOADER_TRUNCATE_EN to deliver oversize messages truncated instead of dropping them.
module eaglesong_msg_loader #(
    parameter int unsigned MAX_BYTES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] input_val,
    output logic [6:0]   input_length_bytes,
    output logic [7:0]   absorb_round_num,
    output logic         len_err,
    output logic [15:0]  msg_count
);

    localparam logic [5:0] LastIdx = 6'(MAX_BYTES - 1);
    localparam logic [6:0] MaxLen  = 7'(MAX_BYTES);

    typedef enum logic [1:0] {StCollect, StDrain, StHold} state_e;

    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [255:0]   buf_q, buf_d;
    logic [6:0]     len_q, len_d;
    logic           len_err_q, len_err_d;
    logic [15:0]    count_q, count_d;
    logic           accept;

    assign accept = in_valid && (state_q != StHold);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        len_d     = len_q;
        len_err_d = 1'b0;
        count_d   = count_q;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    buf_d[{cnt_q[4:0], 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 6'd1;
                    if (in_last) begin
                        len_d   = {1'b0, cnt_q} + 7'd1;
                        state_d = StHold;
                    end else if (cnt_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Bytes past the buffer are discarded until the message terminates.
                if (accept && in_last) begin
                    len_err_d = 1'b1;
`ifdef EAGLESONG_LOADER_TRUNCATE_EN
                    len_d     = MaxLen;
                    state_d   = StHold;
`else
                    buf_d     = '0;
                    cnt_d     = '0;
                    state_d   = StCollect;
`endif
                end
            end
            StHold: begin
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    buf_d   = '0;
                    cnt_d   = '0;
                    len_d   = '0;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCollect;
            cnt_q     <= '0;
            buf_q     <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            count_q   <= count_d;
        end
    end

    assign in_ready           = ~rst & (state_q != StHold);
    assign out_valid          = (state_q == StHold);
    assign input_val          = buf_q;
    assign input_length_bytes = len_q;
    assign absorb_round_num   = 8'd0;
    assign len_err            = len_err_q;
    assign msg_count          = count_q;

endmodule

// File: tb/tb_eaglesong_msg_loader.sv
// Directed self-checking bench for eaglesong_msg_loader; honours EAGLESONG_LOADER_TRUNCATE_EN.
module tb_eaglesong_msg_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] input_val;
    logic [6:0]   input_length_bytes;
    logic [7:0]   absorb_round_num;
    logic         len_err;
    logic [15:0]  msg_count;

    int checks   = 0;
    int failures = 0;

    eaglesong_msg_loader #(.MAX_BYTES(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_last            (in_last),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .input_val          (input_val),
        .input_length_bytes (input_length_bytes),
        .absorb_round_num   (absorb_round_num),
        .len_err            (len_err),
        .msg_count          (msg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; the rising edge between samples them.
    task automatic send_byte(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [255:0] exp_val;
    int           err_hits;
    int           exp_count;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", 256'(in_ready), 256'(1'b0));
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_input_val", input_val, 256'h0);
        check("rst_len", 256'(input_length_bytes), 256'(7'd0));
        check("rst_len_err", 256'(len_err), 256'(1'b0));
        check("rst_msg_count", 256'(msg_count), 256'(16'd0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

        // Single byte
        send_byte(8'hAB, 1'b1);
        check("single_out_valid", 256'(out_valid), 256'(1'b1));
        check("single_val", input_val, 256'hAB);
        check("single_len", 256'(input_length_bytes), 256'(7'd1));
        check("single_round", 256'(absorb_round_num), 256'(8'd0));
        check("single_in_ready", 256'(in_ready), 256'(1'b0));
        consume();
        check("single_count", 256'(msg_count), 256'(16'd1));
        check("single_done", 256'(out_valid), 256'(1'b0));
        exp_count = 1;

        // Full-length 32-byte message
        exp_val = '0;
        for (int i = 0; i < 32; i++) begin
            exp_val[i*8 +: 8] = 8'(i);
            send_byte(8'(i), i == 31);
        end
        check("full_out_valid", 256'(out_valid), 256'(1'b1));
        check("full_len", 256'(input_length_bytes), 256'(7'd32));
        check("full_val", input_val, exp_val);
        check("full_top", 256'(input_val[255:248]), 256'(8'h1F));
        check("full_len_err", 256'(len_err), 256'(1'b0));
        consume();
        exp_count++;
        check("full_count", 256'(msg_count), 256'(exp_count));

        // Backpressure with stray beats during HOLD
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", 256'(out_valid), 256'(1'b1));
            check("bp_val", input_val, 256'h332211);
            check("bp_len", 256'(input_length_bytes), 256'(7'd3));
            check("bp_in_ready", 256'(in_ready), 256'(1'b0));
            in_valid = 1'b1;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_val_end", input_val, 256'h332211);
        consume();
        exp_count++;
        check("bp_count", 256'(msg_count), 256'(exp_count));
        check("bp_idle_in_ready", 256'(in_ready), 256'(1'b1));

        // Oversize 40-byte message
        err_hits = 0;
        exp_val  = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) exp_val[i*8 +: 8] = 8'(8'h40 + i);
            send_byte(8'(8'h40 + i), i == 39);
            if (len_err) err_hits++;
        end
        check("ovr_len_err_now", 256'(len_err), 256'(1'b1));
        check("ovr_len_err_hits", 256'(err_hits), 256'(1));
`ifdef EAGLESONG_LOADER_TRUNCATE_EN
        check("ovr_out_valid", 256'(out_valid), 256'(1'b1));
        check("ovr_len", 256'(input_length_bytes), 256'(7'd32));
        check("ovr_val", input_val, exp_val);
        consume();
        exp_count++;
`else
        check("ovr_out_valid", 256'(out_valid), 256'(1'b0));
        check("ovr_in_ready", 256'(in_ready), 256'(1'b1));
        @(negedge clk);
`endif
        check("ovr_len_err_gone", 256'(len_err), 256'(1'b0));
        check("ovr_count", 256'(msg_count), 256'(exp_count));

        // Follow-up short message must carry no leftover bytes
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b1);
        check("post_ovr_out_valid", 256'(out_valid), 256'(1'b1));
        check("post_ovr_val", input_val, 256'hC2C1);
        check("post_ovr_len", 256'(input_length_bytes), 256'(7'd2));
        consume();
        exp_count++;
        check("post_ovr_count", 256'(msg_count), 256'(exp_count));

        // Reset mid-message
        for (int i = 0; i < 10; i++) send_byte(8'(8'h90 + i), 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_count", 256'(msg_count), 256'(16'd0));
        check("midrst_in_ready", 256'(in_ready), 256'(1'b0));
        check("midrst_val", input_val, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h5A, 1'b1);
        check("midrst_out_valid", 256'(out_valid), 256'(1'b1));
        check("midrst_msg_val", input_val, 256'h5A);
        check("midrst_len", 256'(input_length_bytes), 256'(7'd1));
        consume();
        check("midrst_count_after", 256'(msg_count), 256'(16'd1));

        // Counter wrap: preload the counter to its maximum
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        #1;
        check("wrap_preload", 256'(msg_count), 256'(16'hFFFF));
        send_byte(8'h01, 1'b1);
        consume();
        check("wrap_count", 256'(msg_count), 256'(16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
